seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clocks per digit drive window (1 kHz/digit at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter DEAD_CYCLES, default 16, meaning all-digits-off clocks between windows; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port value_i  input  16  four BCD nibbles; [15:12] is digit 3, the most significant.
REQ-006 SHALL have port load_i  input  1  one-cycle strobe capturing value_i.
REQ-007 SHALL have port lzs_i  input  1  leading-zero suppression enable.
REQ-008 SHALL have port bcd_o  output  4  nibble for the downstream seven-segment decoder.
REQ-009 SHALL have port digit_n_o  output  4  active-low digit enables; bit k drives digit k.
REQ-010 SHALL have port frame_o  output  1  one-cycle pulse at each frame start.

Function
REQ-011 SHALL hold a shadow register, written with value_i on every cycle load_i=1; the last strobe before a frame boundary wins.
REQ-012 SHALL copy shadow to the display register only at a frame boundary (index wrap 3->0) to prevent tearing.
REQ-013 SHALL defer a load_i coinciding with the boundary cycle to the following frame.
REQ-014 SHALL use a two-state FSM: DRIVE, DEAD.
REQ-015 SHALL stay in DRIVE for exactly REFRESH_DIV cycles, then enter DEAD.
REQ-016 SHALL stay in DEAD for exactly DEAD_CYCLES cycles, then increment the digit index (2-bit, wraps 3->0) and enter DRIVE.
REQ-017 SHALL make each digit period REFRESH_DIV+DEAD_CYCLES cycles and each frame 4x that.
REQ-018 SHALL hold digit_n_o=4'b1111 throughout DEAD.
REQ-019 SHALL drive, in DRIVE, digit_n_o with only bit idx low and bcd_o with display nibble idx.
REQ-020 SHALL blank digit k in DRIVE (digit_n_o=4'b1111) when lzs_i=1, k>0, and display nibbles k..3 are all zero; digit 0 is never suppressed.
REQ-021 SHALL pass nibbles >9 unchanged on bcd_o; decoding them is the decoder's job.
REQ-022 SHALL register bcd_o, digit_n_o and frame_o, and change bcd_o only while digit_n_o=4'b1111, so no glitches occur on a lit digit.
REQ-023 SHALL pulse frame_o in the cycle the index wraps 3->0, the same cycle the display register updates.
REQ-024 SHALL make the prescaler counter width $clog2(REFRESH_DIV) and make it terminal-count driven, never free-running.

Reset
REQ-025 SHALL, while rst_n=0, force digit_n_o=4'b1111, bcd_o=0, frame_o=0, index=0, shadow=0, display=0, counters=0, state=DEAD.
REQ-026 SHALL, after release, drive digit 0 first, DEAD_CYCLES cycles after the first rising edge.
REQ-027 SHALL, on reset asserted mid-operation, blank all digits immediately (asynchronously) and discard pending shadow content.

Structure
REQ-028 SHALL place NUM_DIGITS=4, the DIGITS_OFF=4'b1111 constant and the FSM state enum in shared package seg_pkg, also used by the decoder.
REQ-029 SHALL implement the prescaler as sub-module seg_tick_gen (parameter DIV, outputs a one-cycle tick); the FSM and datapath stay in seg_scan_mux.

Verification (REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-030 SHALL cover: reset release, load 16'h1234 -> after the next frame_o, digit_n_o sequence 1110/1101/1011/0111 with bcd_o 4/3/2/1, each lit 8 cycles, 2 dark cycles between.
REQ-031 SHALL cover: lzs_i=1, value 16'h0070 -> digits 3 and 2 stay dark in their windows, digit 1 shows 7, digit 0 shows 0; value 16'h0000 -> only digit 0 lit showing 0.
REQ-032 SHALL cover: load 16'h5555 mid-frame, then 16'h6666 on the boundary cycle -> the current frame finishes with the old value, the next frame shows 5555, and the one after shows 6666.
REQ-033 SHALL cover: rst_n pulled low while digit 2 is lit -> digit_n_o=4'b1111 within the same cycle, with no clock edge required; after release, digit 0 resumes and display is 0000.
REQ-034 SHALL cover: a continuous run of 10 frames -> frame_o period is exactly 40 cycles, no two enable bits ever low at once, and bcd_o is stable whenever any enable is low.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan multiplexer and its decoder.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIGITS_OFF = 4'b1111;

  typedef enum logic [0:0] {
    ST_DRIVE = 1'b0,
    ST_DEAD  = 1'b1
  } scan_state_e;

  // Nibble k of a four-digit BCD word (k=3 is the most significant digit).
  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] k);
    logic [15:0] shifted;
    shifted = word >> {k, 2'b00};
    return shifted[3:0];
  endfunction

  // True when digit k is a leading zero: k>0 and nibbles k..3 are all zero.
  function automatic logic lz_blank(input logic [15:0] word, input logic [1:0] k);
    logic [15:0] shifted;
    shifted = word >> {k, 2'b00};
    return (k != 2'd0) && (shifted == 16'd0);
  endfunction

  // Active-low enable pattern with only digit k driven.
  function automatic logic [3:0] digit_onehot_n(input logic [1:0] k);
    return ~(4'b0001 << k);
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Terminal-count prescaler: while enabled, emits a one-cycle tick every DIV
// clocks and returns to zero; holds its count while disabled.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int         W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrapping to zero on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed display scanner. Each digit gets a drive window of
// REFRESH_DIV clocks followed by DEAD_CYCLES dark clocks. New values are staged
// in a shadow register and only shown from the next frame boundary on, so a
// frame never mixes two values. bcd_o is reloaded one dark cycle ahead of each
// window so it never moves under a lit digit.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic        lzs_i,
  output logic [3:0]  bcd_o,
  output logic [3:0]  digit_n_o,
  output logic        frame_o
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);
  localparam logic [7:0] DEAD_PRE  = 8'(DEAD_CYCLES - 2);

  scan_state_e state, state_next;
  logic [1:0]  idx, idx_up, idx_next;
  logic        first_window;
  logic [7:0]  dead_cnt;
  logic [15:0] shadow, shadow_next, display, display_next, preload_disp;
  logic        tick, dead_done, wrap, preload;
  logic [3:0]  bcd_d, digit_n_d;
  logic        frame_d;

  seg_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_DRIVE),
    .tick (tick)
  );

  // The first dark gap after reset leads into digit 0 rather than advancing.
  assign dead_done    = (state == ST_DEAD) && (dead_cnt == DEAD_LAST);
  assign idx_up       = first_window ? 2'd0 : idx + 2'd1;
  assign idx_next     = dead_done ? idx_up : idx;
  assign wrap         = dead_done && !first_window && (idx == 2'd3);
  assign shadow_next  = load_i ? value_i : shadow;
  assign display_next = wrap ? shadow : display;
  // Edge entering the last dark cycle before a window: time to preload bcd_o.
  assign preload      = (DEAD_CYCLES == 1) ? ((state == ST_DRIVE) && tick)
                                           : ((state == ST_DEAD) && (dead_cnt == DEAD_PRE));
  // On the way into a frame boundary, display will take the shadow as it
  // stands after this edge; any load on the boundary cycle itself is deferred.
  assign preload_disp = (!first_window && (idx == 2'd3)) ? shadow_next : display;

  // FSM state register plus scan index, dead counter and value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_DEAD;
      idx          <= 2'd0;
      first_window <= 1'b1;
      dead_cnt     <= 8'd0;
      shadow       <= 16'd0;
      display      <= 16'd0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      first_window <= dead_done ? 1'b0 : first_window;
      dead_cnt     <= (state == ST_DEAD && !dead_done) ? dead_cnt + 8'd1 : 8'd0;
      shadow       <= shadow_next;
      display      <= display_next;
    end
  end

  // FSM next-state: DRIVE until the prescaler tick, DEAD until the gap elapses.
  always_comb begin
    state_next = state;
    case (state)
      ST_DRIVE: state_next = tick ? ST_DEAD : ST_DRIVE;
      ST_DEAD:  state_next = dead_done ? ST_DRIVE : ST_DEAD;
      default:  state_next = ST_DEAD;
    endcase
  end

  // FSM outputs computed from the state being entered so registers line up.
  always_comb begin
    frame_d = wrap;
    if (preload) begin
      bcd_d = nibble_of(preload_disp, idx_up);
    end else begin
      bcd_d = bcd_o;
    end
    if ((state_next == ST_DRIVE) && !(lzs_i && lz_blank(display_next, idx_next))) begin
      digit_n_d = digit_onehot_n(idx_next);
    end else begin
      digit_n_d = DIGITS_OFF;
    end
  end

  // Output registers; reset blanks the digits immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_o     <= 4'd0;
      digit_n_o <= DIGITS_OFF;
      frame_o   <= 1'b0;
    end else begin
      bcd_o     <= bcd_d;
      digit_n_o <= digit_n_d;
      frame_o   <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (REFRESH_DIV=8, DEAD_CYCLES=2).
module tb_seg_scan_mux;

  localparam int R = 8;
  localparam int D = 2;
  localparam int P = R + D;
  localparam int F = 4 * P;

  typedef struct packed {
    logic        lzs;
    logic [15:0] val;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = 16'd0;
  logic        load_i = 1'b0;
  logic        lzs_i = 1'b0;
  logic [3:0]  bcd_o;
  logic [3:0]  digit_n_o;
  logic        frame_o;

  int     total = 0;
  int     bad = 0;
  int     c = 0;
  logic [15:0] shadow_m = 16'd0;
  frame_t exp_q[$];

  seg_scan_mux #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_i  (value_i),
    .load_i   (load_i),
    .lzs_i    (lzs_i),
    .bcd_o    (bcd_o),
    .digit_n_o(digit_n_o),
    .frame_o  (frame_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h, want %h", name, $time, act, req);
    end
  endtask

  // Reference: digit k of a frame is dark when suppressed as a leading zero.
  function automatic logic [3:0] exp_enable(input frame_t f, input int k);
    logic [15:0] upper;
    upper = f.val >> (4 * k);
    if (f.lzs && k > 0 && upper == 16'd0) return 4'b1111;
    return 4'b1111 ^ (4'b0001 << k);
  endfunction

  function automatic logic [3:0] exp_nibble(input frame_t f, input int k);
    logic [15:0] upper;
    upper = f.val >> (4 * k);
    return upper[3:0];
  endfunction

  // Last cycle of each frame after reset: the next cycle starts a new frame.
  function automatic bit is_bnd(input int cc);
    return (cc >= D + F - 1) && (((cc - (D - 1)) % F) == 0);
  endfunction

  // Drive one cycle of stimulus; the frame that will follow a boundary shows
  // the last value loaded before the boundary cycle.
  task automatic tick(input bit ld, input logic [15:0] v);
    load_i  = ld;
    value_i = v;
    if (is_bnd(c)) exp_q.push_back({lzs_i, shadow_m});
    if (ld) shadow_m = v;
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic to_boundary();
    while (!is_bnd(c)) tick(1'b0, 16'd0);
  endtask

  // Hold reset a few cycles, release, and check the first digit comes up.
  task automatic reset_and_check();
    rst_n  = 1'b0;
    load_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_digits", {28'd0, digit_n_o}, 32'hF);
      check("rst_bcd", {28'd0, bcd_o}, 32'h0);
      check("rst_frame", {31'd0, frame_o}, 32'h0);
    end
    rst_n    = 1'b1;
    c        = 0;
    shadow_m = 16'd0;
    for (int i = 0; i < D; i++) begin
      check("dark_after_rst", {28'd0, digit_n_o}, 32'hF);
      tick(1'b0, 16'd0);
    end
    check("first_digit0", {28'd0, digit_n_o}, 32'hE);
    check("first_bcd", {28'd0, bcd_o}, 32'h0);
  endtask

  // Monitor: frame_o opens a 40-cycle window checked against the scoreboard.
  initial begin
    int     t;
    int     k;
    int     off;
    bit     active;
    longint ncyc;
    longint last_f;
    logic [3:0] prev_bcd;
    frame_t cur;
    t = 0; active = 1'b0; ncyc = 0; last_f = -1; prev_bcd = 4'd0; cur = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        exp_q.delete();
        active = 1'b0;
        last_f = -1;
      end else begin
        check("one_lit", {31'd0, ($countones(~digit_n_o) <= 1)}, 32'd1);
        if (digit_n_o != 4'b1111) check("bcd_stable", {28'd0, bcd_o}, {28'd0, prev_bcd});
        if (frame_o) begin
          if (last_f >= 0) check("frame_period", 32'(ncyc - last_f), 32'(F));
          last_f = ncyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected at t=%0t: frame_o with no frame due", $time);
            active = 1'b0;
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            t      = 0;
          end
        end
        if (active) begin
          k   = t / P;
          off = t % P;
          if (off < R) begin
            check("digit_en", {28'd0, digit_n_o}, {28'd0, exp_enable(cur, k)});
            if (exp_enable(cur, k) != 4'b1111)
              check("digit_bcd", {28'd0, bcd_o}, {28'd0, exp_nibble(cur, k)});
          end else begin
            check("dead_dark", {28'd0, digit_n_o}, 32'hF);
          end
          t++;
          if (t == F) active = 1'b0;
        end
      end
      prev_bcd = bcd_o;
    end
  end

  // Stimulus.
  initial begin
    int n;
    logic [15:0] rv;
    reset_and_check();

    // Plain load, shown from the following frame.
    repeat (3) tick(1'b0, 16'd0);
    tick(1'b1, 16'h1234);
    to_boundary();
    repeat (2 * F) tick(1'b0, 16'd0);

    // Leading-zero suppression.
    tick(1'b1, 16'h0070);
    to_boundary();
    lzs_i = 1'b1;
    repeat (F) tick(1'b0, 16'd0);
    tick(1'b1, 16'h0000);
    to_boundary();
    repeat (2 * F) tick(1'b0, 16'd0);

    // Mid-frame load followed by a load on the boundary cycle.
    to_boundary();
    lzs_i = 1'b0;
    repeat (16) tick(1'b0, 16'd0);
    tick(1'b1, 16'h5555);
    to_boundary();
    tick(1'b1, 16'h6666);
    repeat (2 * F) tick(1'b0, 16'd0);

    // Randomized loads and suppression over ten frames.
    repeat (10) begin
      to_boundary();
      lzs_i = 1'($urandom_range(0, 1));
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      tick(1'($urandom_range(0, 3) == 0), rv);
      repeat (F - 1) begin
        rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
        tick(1'($urandom_range(0, 7) == 0), rv);
      end
    end

    // Asynchronous reset while digit 2 is lit.
    lzs_i = 1'b0;
    tick(1'b1, 16'h4321);
    n = 0;
    while (digit_n_o !== 4'b1011 && n < 4 * F) begin
      tick(1'b0, 16'd0);
      n++;
    end
    check("wait_digit2", {28'd0, digit_n_o}, 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_blank", {28'd0, digit_n_o}, 32'hF);
    reset_and_check();
    repeat (2 * F) tick(1'b0, 16'd0);

    repeat (3) tick(1'b0, 16'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
